// File: rtl/fx3_slave_fifo_writer_pkg.sv
// fx3_slave_fifo_writer_pkg: shared FSM state encoding and default FX3 thread for the slave FIFO writer
package fx3_slave_fifo_writer_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_PKTEND = 2'd3;
   localparam logic [1:0] DEFAULT_THREAD = 2'd0;
endpackage

// File: rtl/fx3_slave_fifo_writer_sync_word_fifo.sv
// sync_word_fifo: single-clock word buffer with full/empty flags
//   clk, reset_n        : clock, asynchronous active-low reset
//   push, push_data     : write request and word
//   pop, pop_data       : read request and head word (valid while not empty)
//   full, empty         : occupancy flags
module sync_word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   // extra pointer bit separates full from empty when the indices match
   assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
   assign empty = wr_ptr == rd_ptr;
   assign pop_data = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
endmodule

// File: rtl/fx3_slave_fifo_writer.sv
// fx3_slave_fifo_writer: buffers CSI bridge words and writes them to an FX3 slave FIFO thread
//   clk_i, reset_n_i            : clock, asynchronous active-low reset
//   data_i, data_valid_i        : bridge word and its valid
//   frame_sync_i                : high while a frame is active
//   fx3_ready_i                 : FX3 thread can accept a write
//   fx3_data_o, fx3_slwr_n_o    : slave FIFO data and write strobe
//   fx3_pktend_n_o, fx3_addr_o  : packet end strobe and thread select
//   overflow_o, frame_count_o   : sticky drop flag and completed frame count
// Define FX3_PKTEND_EN to close each frame with a PKTEND strobe.
module fx3_slave_fifo_writer
   import fx3_slave_fifo_writer_pkg::*;
#(
   parameter int         FIFO_DEPTH   = 16,
   parameter int         PACKET_WORDS = 1024,
   parameter logic [1:0] FX3_THREAD   = DEFAULT_THREAD
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [31:0] data_i,
   input  logic        data_valid_i,
   input  logic        frame_sync_i,
   input  logic        fx3_ready_i,
   output logic [31:0] fx3_data_o,
   output logic        fx3_slwr_n_o,
   output logic        fx3_pktend_n_o,
   output logic [1:0]  fx3_addr_o,
   output logic        overflow_o,
   output logic [15:0] frame_count_o
);
   localparam int PW = $clog2(PACKET_WORDS);
`ifdef FX3_PKTEND_EN
   localparam logic [1:0] FLUSH_EXIT = ST_PKTEND;
`else
   localparam logic [1:0] FLUSH_EXIT = ST_IDLE;
`endif
   logic [1:0] state, nxt;
   logic fs_q, pending, in_valid, full, empty, push, pop, drop, rise, fall, tail, done, start;
   logic [31:0] in_data, fifo_data;
   logic [PW-1:0] pkt_cnt;
   assign fx3_addr_o = FX3_THREAD;
   sync_word_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk_i), .reset_n(reset_n_i), .push(push), .push_data(in_data),
      .pop(pop), .pop_data(fifo_data), .full(full), .empty(empty)
   );
   always_comb begin
      rise = frame_sync_i && !fs_q;
      fall = !frame_sync_i && fs_q;
      tail = state == ST_FLUSH || state == ST_PKTEND;
      pop = !empty && fx3_ready_i && (state == ST_STREAM || state == ST_FLUSH);
      // a concurrent pop frees the slot a full buffer needs
      drop = in_valid && (state != ST_STREAM || (full && !pop));
      push = in_valid && !drop;
      nxt = state == ST_IDLE ? ((rise || pending) ? ST_STREAM : ST_IDLE) :
            state == ST_STREAM ? (fall ? ST_FLUSH : ST_STREAM) :
            state == ST_FLUSH ? (empty ? FLUSH_EXIT : ST_FLUSH) : ST_IDLE;
`ifdef FX3_PKTEND_EN
      if (state == ST_PKTEND) nxt = fx3_ready_i ? ST_IDLE : ST_PKTEND;
`endif
      done = tail && nxt == ST_IDLE;
      start = state == ST_IDLE && nxt == ST_STREAM;
   end
   // the input register stage gives the two-cycle input-to-strobe latency
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state <= ST_IDLE;
         fs_q <= 1'b0;
         pending <= 1'b0;
         in_valid <= 1'b0;
         in_data <= '0;
         pkt_cnt <= '0;
         fx3_data_o <= '0;
         fx3_slwr_n_o <= 1'b1;
         overflow_o <= 1'b0;
         frame_count_o <= '0;
      end else begin
         state <= nxt;
         fs_q <= frame_sync_i;
         in_valid <= data_valid_i;
         in_data <= data_i;
         fx3_slwr_n_o <= !pop;
         if (pop) fx3_data_o <= fifo_data;
         if (drop) overflow_o <= 1'b1;
         if (done) frame_count_o <= frame_count_o + 1'b1;
         pending <= start ? 1'b0 : (pending || (rise && tail));
         // FX3 auto-commits full packets, so the counter wraps at the packet size
         pkt_cnt <= (start || done) ? '0 :
                    pop ? (pkt_cnt == PW'(PACKET_WORDS - 1) ? '0 : pkt_cnt + 1'b1) : pkt_cnt;
      end
`ifdef FX3_PKTEND_EN
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) fx3_pktend_n_o <= 1'b1;
      else fx3_pktend_n_o <= !(state == ST_PKTEND && fx3_ready_i);
`else
   assign fx3_pktend_n_o = 1'b1;
`endif
endmodule

// File: tb/tb_fx3_slave_fifo_writer.sv
// tb_fx3_slave_fifo_writer: directed and randomized checks of the FX3 slave FIFO writer
module tb_fx3_slave_fifo_writer;
`ifdef FX3_PKTEND_EN
   localparam int PKE = 1;
`else
   localparam int PKE = 0;
`endif
   typedef struct { logic [31:0] d; int c; } ev_t;
   logic clk = 1'b0, reset_n = 1'b1, valid = 1'b0, fs = 1'b0, ready = 1'b0;
   logic [31:0] din = '0, dout;
   logic slwr_n, pktend_n, ovf, rdy_q = 1'b0, exp_ovf = 1'b0;
   logic [1:0] addr;
   logic [15:0] fc;
   ev_t sq[$], exp_q[$];
   int cyc = 0, n_chk = 0, n_fail = 0, pk_cnt = 0, pk_cyc = 0, bad_both = 0, bad_rdy = 0, exp_fc = 0;

   fx3_slave_fifo_writer dut (
      .clk_i(clk), .reset_n_i(reset_n), .data_i(din), .data_valid_i(valid),
      .frame_sync_i(fs), .fx3_ready_i(ready), .fx3_data_o(dout), .fx3_slwr_n_o(slwr_n),
      .fx3_pktend_n_o(pktend_n), .fx3_addr_o(addr), .overflow_o(ovf), .frame_count_o(fc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      rdy_q <= ready;
   end
   always @(negedge clk) begin
      if (!slwr_n) sq.push_back('{dout, cyc});
      if (!pktend_n) begin
         pk_cnt++;
         pk_cyc = cyc;
      end
      if (!slwr_n && !pktend_n) bad_both++;
      if ((!slwr_n || !pktend_n) && !rdy_q) bad_rdy++;
   end

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(bit f, bit v, logic [31:0] d, bit r);
      @(negedge clk);
      fs = f; valid = v; din = d; ready = r;
   endtask

   task automatic send(logic [31:0] d, bit r, bit acc);
      step(1'b1, 1'b1, d, r);
      if (acc) exp_q.push_back('{d, cyc + 1});
   endtask

   task automatic idle(int n, bit f, bit r);
      repeat (n) step(f, 1'b0, '0, r);
   endtask

   task automatic cmp(string tag, bit timed);
      #1;
      chk({tag, " count"}, 64'(sq.size()), 64'(exp_q.size()));
      for (int i = 0; i < sq.size() && i < exp_q.size(); i++) begin
         chk({tag, " data"}, 64'(sq[i].d), 64'(exp_q[i].d));
         if (timed) chk({tag, " latency"}, 64'(sq[i].c - exp_q[i].c), 64'd2);
      end
      sq.delete();
      exp_q.delete();
   endtask

   task automatic finish_frame(string tag, bit timed, int n);
      int last;
      step(1'b0, 1'b0, '0, 1'b1);
      idle(n, 1'b0, 1'b1);
      #1;
      last = sq.size() > 0 ? sq[sq.size() - 1].c : 0;
      exp_fc++;
      chk({tag, " pktend count"}, 64'(pk_cnt), 64'(PKE));
      chk({tag, " pktend after data"}, 64'(pk_cnt == 0 || pk_cyc > last), 64'd1);
      chk({tag, " frame_count"}, 64'(fc), 64'(16'(exp_fc)));
      chk({tag, " overflow"}, 64'(ovf), 64'(exp_ovf));
      cmp(tag, timed);
      pk_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int occ, sent;
      #1 reset_n = 1'b0;
      #1;
      chk("rst slwr_n", 64'(slwr_n), 64'd1);
      chk("rst pktend_n", 64'(pktend_n), 64'd1);
      chk("rst data", 64'(dout), 64'd0);
      chk("rst overflow", 64'(ovf), 64'd0);
      chk("rst frame_count", 64'(fc), 64'd0);
      chk("addr", 64'(addr), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(3, 1'b0, 1'b1);
      // eight sequential words, ready held high
      for (int i = 1; i <= 8; i++) send(32'(i), 1'b1, 1'b1);
      finish_frame("s1", 1'b1, 12);
      // full packet of random words
      for (int i = 0; i < 1024; i++) send($urandom, 1'b1, 1'b1);
      finish_frame("s2", 1'b1, 12);
      // sparse words with random backpressure
      sent = 0;
      while (sent < 14) begin
         if ($urandom_range(1, 0) == 1) begin
            send($urandom, 1'($urandom_range(1, 0)), 1'b1);
            sent++;
         end else step(1'b1, 1'b0, '0, 1'($urandom_range(1, 0)));
      end
      repeat (60) step(1'b0, 1'b0, '0, 1'($urandom_range(1, 0)));
      finish_frame("s2b", 1'b0, 20);
      // overflow: FX3 stalled through 20 words
      occ = 0;
      for (int i = 0; i < 20; i++) begin
         if (occ >= 16) exp_ovf = 1'b1;
         send(32'hA000_0000 + 32'(i), 1'b0, occ < 16);
         if (occ < 16) occ++;
      end
      idle(5, 1'b0, 1'b0);
      #1;
      chk("s3 no strobe while stalled", 64'(sq.size()), 64'd0);
      chk("s3 overflow set", 64'(ovf), 64'd1);
      finish_frame("s3", 1'b0, 30);
      // back-to-back frames: restart one cycle after the fall
      for (int i = 0; i < 3; i++) send(32'hB000_0000 + 32'(i), 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0);
      idle(10, 1'b1, 1'b1);
      #1;
      exp_fc++;
      chk("s4 first frame_count", 64'(fc), 64'(16'(exp_fc)));
      chk("s4 first pktend", 64'(pk_cnt), 64'(PKE));
      cmp("s4a", 1'b0);
      pk_cnt = 0;
      for (int i = 0; i < 4; i++) send(32'hC000_0000 + 32'(i), 1'b1, 1'b1);
      finish_frame("s4b", 1'b1, 12);
      // reset mid-frame with buffered words
      for (int i = 0; i < 5; i++) send(32'hD000_0000 + 32'(i), 1'b0, 1'b0);
      idle(2, 1'b1, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("s5 slwr_n", 64'(slwr_n), 64'd1);
      chk("s5 pktend_n", 64'(pktend_n), 64'd1);
      chk("s5 data", 64'(dout), 64'd0);
      chk("s5 overflow", 64'(ovf), 64'd0);
      chk("s5 frame_count", 64'(fc), 64'd0);
      fs = 1'b0; valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_fc = 0;
      exp_ovf = 1'b0;
      idle(10, 1'b0, 1'b1);
      #1;
      chk("s5 no strobes after reset", 64'(sq.size()), 64'd0);
      chk("s5 no pktend after reset", 64'(pk_cnt), 64'd0);
      for (int i = 0; i < 3; i++) send(32'hE000_0000 + 32'(i), 1'b1, 1'b1);
      finish_frame("s5", 1'b1, 12);
      // frame counter wrap
      @(negedge clk);
      force dut.frame_count_o = 16'hFFFF;
      #1 release dut.frame_count_o;
      exp_fc = 16'hFFFF;
      send(32'h1234_5678, 1'b1, 1'b1);
      finish_frame("s6", 1'b1, 12);
      chk("never both strobes low", 64'(bad_both), 64'd0);
      chk("no strobe without ready", 64'(bad_rdy), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
